imu_sample_filter: RTL and testbench
====================================

Name: imu_sample_filter

Overview:
Consumes the six raw 16-bit accelerometer/gyro words produced by the MPU I2C reader, once per completed burst.
- Subtracts a host-programmed per-channel offset.
- Block-averages 2^AVG_LOG2 samples per channel, processing one channel per cycle.
- Exposes the filtered values, offsets and status through a small host register port for the Patmos I/O device wrapper.

Parameters:
AVG_LOG2, 2, log2 of samples per average block; legal 0..6 (0 = pass-through after offset).
CNT_W, 16, width of the sample counter in status.

Ports:
clk  in  1  system clock
reset_n  in  1  reset
sample_strobe  in  1  one-cycle pulse: raw_0..raw_5 hold a new burst
raw_0..raw_5  in  16 each  raw two's-complement samples (accX,accY,accZ,gyroX,gyroY,gyroZ)
address  in  4  host register address
wr  in  1  host write strobe
wr_data  in  16  host write data
rd_data  out  32  registered read data
out_valid  out  1  one-cycle pulse: filtered registers updated
busy  out  1  processing in progress

Interface (Already decided):
- One clock, clk; reset is asynchronous and active-low on reset_n.

Behaviour:
- Reset values:
  - rd_data=0, out_valid=0, busy=0.
  - All accumulators, filtered registers, offsets, block counter, sample counter and overrun flag cleared.
  - State IDLE.
  - Reset mid-operation aborts processing; the partial block is lost.
- States and transitions:
  - IDLE: sample_strobe=1 latches raw_0..5 and snapshots offsets 0..5 into working copies; ch<=0; go CAL.
  - CAL (6 cycles, ch 0..5):
    - d = raw[ch] - off[ch] in 17 bits, reduced to 16 bits (see optional feature).
    - If block_cnt < 2^AVG_LOG2-1: acc[ch] += sext(d).
    - Else: filt[ch] <= (acc[ch]+sext(d)) >>> AVG_LOG2 (arithmetic), acc[ch] <= 0.
    - After ch=5 go DONE.
  - DONE (1 cycle):
    - block_cnt wraps modulo 2^AVG_LOG2.
    - sample_count += 1, wrapping at 2^CNT_W.
    - out_valid=1 only if this sample closed a block; go IDLE.
- Latency: strobe at cycle 0, CAL at cycles 1..6, DONE at cycle 7, new filt readable from cycle 8.
- busy=1 in CAL and DONE.
- sample_strobe while busy: sample dropped, overrun sticky set. Simultaneous strobe and overrun-clear write: set wins.
- Accumulator width: 16+AVG_LOG2 signed; no overflow possible.
- Register map:
  - 0..5: filt[0..5], sign-extended to 32.
  - 6: status {sample_count[CNT_W-1:0] in [31:16], 14'b0, overrun [1], busy [0]}; write with wr_data[1]=1 clears overrun.
  - 8..13: offset[0..5] (R/W, sign-extended on read).
  - Other addresses read 0; writes to them are ignored.
- rd_data updates one cycle after address.
- Offset writes take effect at the next sample latch. A write landing in the same cycle as a latching strobe is not used by that sample.

Optional Feature:
IMU_FILTER_SAT_EN
- Defined: the offset subtraction saturates to [-32768, 32767].
- Undefined: the low 16 bits are kept (two's-complement wrap).

Decomposition:
- Package imu_filter_pkg:
  - state enum (IDLE, CAL, DONE)
  - register address constants (FILT_BASE=0, STATUS=6, OFF_BASE=8)
  - channel count NCH=6
- One sub-module imu_off_sub: 16-bit minus 16-bit to 16-bit, containing the IMU_FILTER_SAT_EN choice.

Test Plan:
1. AVG_LOG2=0, offsets 0, raw_0=0x1234, strobe → out_valid at cycle 7; read addr 0 → 0x00001234.
2. AVG_LOG2=2, offset[1]=100, four strobes with raw_1=200,300,400,500 → one out_valid after the 4th; addr 1 reads 250; status count=4.
3. Strobe at cycle 3 of processing → sample dropped; status bit1=1; write 0x0002 to addr 6 → bit1=0.
4. raw_2=0x8000, offset[2]=1 → 0xFFFF8000 with IMU_FILTER_SAT_EN, 0x00007FFF without.
5. Offset write in the same cycle as a latching strobe → that sample uses the old offset; the next sample uses the new one.
6. Assert reset_n=0 mid-CAL → all outputs 0, accumulators cleared; the next 4-sample block averages correctly.

Source files
------------

// File: rtl/imu_filter_pkg.sv
// Shared types and constants for the IMU sample filter: FSM states,
// host register map and channel count.
package imu_filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NCH = 6;

    localparam logic [3:0] FILT_BASE = 4'd0;
    localparam logic [3:0] STATUS    = 4'd6;
    localparam logic [3:0] OFF_BASE  = 4'd8;
    localparam logic [3:0] NCH_A     = 4'(NCH);
    localparam logic [2:0] LAST_CH   = 3'(NCH - 1);

endpackage

// File: rtl/imu_sample_filter_off_sub.sv
// Offset subtraction, 16 - 16 -> 16 bits. IMU_FILTER_SAT_EN selects
// saturation to the signed 16-bit range instead of two's-complement wrap.
module imu_off_sub (
    input  logic [15:0] raw,
    input  logic [15:0] off,
    output logic [15:0] diff
);

`ifdef IMU_FILTER_SAT_EN
    logic signed [16:0] wide;

    assign wide = $signed({raw[15], raw}) - $signed({off[15], off});

    always_comb begin
        diff = wide[15:0];
        if (wide[16] != wide[15]) begin
            diff = wide[16] ? 16'h8000 : 16'h7fff;
        end
    end
`else
    assign diff = raw - off;
`endif

endmodule

// File: rtl/imu_sample_filter.sv
// IMU sample filter: per-channel offset removal and 2^AVG_LOG2 block
// averaging, one channel per cycle, with a host register port. Optional macro IMU_FILTER_SAT_EN.
//
// state | meaning
// IDLE  | waiting for sample_strobe
// CAL   | processing channel ch (0..5), one per cycle
// DONE  | advance block/sample counters, pulse out_valid on block close
module imu_sample_filter
    import imu_filter_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_strobe,
    input  logic [15:0] raw_0,
    input  logic [15:0] raw_1,
    input  logic [15:0] raw_2,
    input  logic [15:0] raw_3,
    input  logic [15:0] raw_4,
    input  logic [15:0] raw_5,
    input  logic [3:0]  address,
    input  logic        wr,
    input  logic [15:0] wr_data,
    output logic [31:0] rd_data,
    output logic        out_valid,
    output logic        busy
);

    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int BC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [BC_W-1:0] BLK_LAST = BC_W'((1 << AVG_LOG2) - 1);

    state_t state, state_nxt;

    logic [2:0]              ch;
    logic [15:0]             raw_in [NCH];
    logic [15:0]             raw_w  [NCH];
    logic [15:0]             off_w  [NCH];
    logic [15:0]             off_r  [NCH];
    logic [15:0]             filt   [NCH];
    logic signed [ACC_W-1:0] acc    [NCH];
    logic signed [ACC_W-1:0] acc_sum;
    logic [BC_W-1:0]         block_cnt;
    logic [CNT_W-1:0]        sample_count;
    logic                    overrun;
    logic                    blk_last;
    logic [15:0]             d;
    logic                    wr_off;
    logic                    wr_status;
    logic [2:0]              off_idx;
    logic [31:0]             rd_nxt;

    always_comb begin
        raw_in[0] = raw_0;
        raw_in[1] = raw_1;
        raw_in[2] = raw_2;
        raw_in[3] = raw_3;
        raw_in[4] = raw_4;
        raw_in[5] = raw_5;
    end

    imu_off_sub u_off (
        .raw  (raw_w[ch]),
        .off  (off_w[ch]),
        .diff (d)
    );

    assign blk_last  = (block_cnt == BLK_LAST);
    assign acc_sum   = acc[ch] + ACC_W'($signed(d));
    assign wr_off    = wr && (address >= OFF_BASE) && (address < OFF_BASE + NCH_A);
    assign wr_status = wr && (address == STATUS);
    assign off_idx   = 3'(address - OFF_BASE);

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (sample_strobe) state_nxt = CAL;
            end
            CAL: begin
                busy = 1'b1;
                if (ch == LAST_CH) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = blk_last;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_nxt = '0;
        if (address < FILT_BASE + NCH_A) begin
            rd_nxt = {{16{filt[3'(address - FILT_BASE)][15]}}, filt[3'(address - FILT_BASE)]};
        end else if (address == STATUS) begin
            rd_nxt = {16'(sample_count), 14'b0, overrun, busy};
        end else if (wr_off || ((address >= OFF_BASE) && (address < OFF_BASE + NCH_A))) begin
            rd_nxt = {{16{off_r[off_idx][15]}}, off_r[off_idx]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ch           <= '0;
            block_cnt    <= '0;
            sample_count <= '0;
            overrun      <= 1'b0;
            rd_data      <= '0;
            for (int i = 0; i < NCH; i++) begin
                raw_w[i] <= '0;
                off_w[i] <= '0;
                off_r[i] <= '0;
                filt[i]  <= '0;
                acc[i]   <= '0;
            end
        end else begin
            state   <= state_nxt;
            rd_data <= rd_nxt;

            if (wr_off) off_r[off_idx] <= wr_data;

            // a strobe arriving while busy beats a same-cycle clear
            if (sample_strobe && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (wr_status && wr_data[1]) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sample_strobe) begin
                        ch <= '0;
                        for (int i = 0; i < NCH; i++) begin
                            raw_w[i] <= raw_in[i];
                            off_w[i] <= off_r[i];
                        end
                    end
                end
                CAL: begin
                    if (blk_last) begin
                        filt[ch] <= 16'(acc_sum >>> AVG_LOG2);
                        acc[ch]  <= '0;
                    end else begin
                        acc[ch]  <= acc_sum;
                    end
                    ch <= ch + 3'd1;
                end
                DONE: begin
                    block_cnt    <= blk_last ? '0 : block_cnt + 1'b1;
                    sample_count <= sample_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imu_sample_filter.sv
// Directed bench for imu_sample_filter: one pass-through instance (AVG_LOG2=0)
// and one 4-sample averaging instance sharing all inputs, checked against a scoreboard.
module tb_imu_sample_filter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_strobe;
    logic [15:0] raw_0, raw_1, raw_2, raw_3, raw_4, raw_5;
    logic [3:0]  address;
    logic        wr;
    logic [15:0] wr_data;
    logic [31:0] rd0, rd4;
    logic        ov0, ov4, busy0, busy4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0]      off_m [6];
    int               acc_m [6];
    int               bc_m;
    int               cnt_m;
    logic             ovr_m;
    logic [5:0][15:0] last0, last4;
    logic [5:0][15:0] q0 [$];
    logic [5:0][15:0] q4 [$];

    always #5 clk = ~clk;

    imu_sample_filter #(.AVG_LOG2(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .sample_strobe(sample_strobe),
        .raw_0(raw_0), .raw_1(raw_1), .raw_2(raw_2), .raw_3(raw_3), .raw_4(raw_4), .raw_5(raw_5),
        .address(address), .wr(wr), .wr_data(wr_data),
        .rd_data(rd0), .out_valid(ov0), .busy(busy0)
    );

    imu_sample_filter #(.AVG_LOG2(2), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .sample_strobe(sample_strobe),
        .raw_0(raw_0), .raw_1(raw_1), .raw_2(raw_2), .raw_3(raw_3), .raw_4(raw_4), .raw_5(raw_5),
        .address(address), .wr(wr), .wr_data(wr_data),
        .rd_data(rd4), .out_valid(ov4), .busy(busy4)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [15:0] sub_m(input logic [15:0] r, input logic [15:0] o);
        int t;
        t = int'($signed(r)) - int'($signed(o));
`ifdef IMU_FILTER_SAT_EN
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
`endif
        return t[15:0];
    endfunction

    function automatic logic [5:0][15:0] mk(input logic [15:0] a0, a1, a2, a3, a4, a5);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            off_m[i] = '0;
            acc_m[i] = 0;
        end
        bc_m  = 0;
        cnt_m = 0;
        ovr_m = 1'b0;
        last0 = '0;
        last4 = '0;
        q0.delete();
        q4.delete();
    endtask

    task automatic model_wr(input logic [3:0] a, input logic [15:0] dv);
        if (a >= 4'd8 && a <= 4'd13) off_m[int'(a) - 8] = dv;
        if (a == 4'd6 && dv[1]) ovr_m = 1'b0;
    endtask

    task automatic model_sample(input logic [5:0][15:0] r, output logic closes);
        logic [5:0][15:0] e0, e4;
        logic [15:0]      dv;
        e4 = '0;
        for (int i = 0; i < 6; i++) begin
            dv       = sub_m(r[i], off_m[i]);
            e0[i]    = dv;
            acc_m[i] = acc_m[i] + int'($signed(dv));
            if (bc_m == 3) begin
                e4[i]    = 16'(acc_m[i] >>> 2);
                acc_m[i] = 0;
            end
        end
        closes = (bc_m == 3);
        q0.push_back(e0);
        if (closes) q4.push_back(e4);
        bc_m  = (bc_m + 1) % 4;
        cnt_m = cnt_m + 1;
    endtask

    task automatic rd_reg(input logic [3:0] a);
        address = a;
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] dv);
        address = a;
        wr_data = dv;
        wr      = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        model_wr(a, dv);
    endtask

    // Strobe one burst, optionally re-strobe at processing cycle drop_cyc and/or
    // issue a host write in the strobe cycle; then scoreboard-check all filt regs.
    task automatic run_sample(input logic [5:0][15:0] r, input int drop_cyc,
                              input logic do_wr, input logic [3:0] wa, input logic [15:0] wd);
        logic closes;
        int   n;
        model_sample(r, closes);
        if (do_wr) model_wr(wa, wd);
        {raw_5, raw_4, raw_3, raw_2, raw_1, raw_0} = r;
        sample_strobe = 1'b1;
        wr      = do_wr;
        address = wa;
        wr_data = wd;
        @(negedge clk);
        sample_strobe = 1'b0;
        wr = 1'b0;
        n = 1;
        while (n < 12 && ov0 !== 1'b1) begin
            sample_strobe = (n == drop_cyc);
            if (n == drop_cyc) begin
                ovr_m = 1'b1;
                {raw_5, raw_4, raw_3, raw_2, raw_1, raw_0} = ~r;
            end
            @(negedge clk);
            n++;
        end
        sample_strobe = 1'b0;
        check("latency", 32'(n), 32'd7);
        check("out_valid_avg", {31'b0, ov4}, {31'b0, closes});
        check("busy_done", {31'b0, busy4}, 32'd1);
        if (ov0 === 1'b1) begin
            check("sb0_depth", 32'(q0.size()), 32'd1);
            if (q0.size() > 0) last0 = q0.pop_front();
        end
        if (ov4 === 1'b1) begin
            check("sb4_depth", 32'(q4.size()), 32'd1);
            if (q4.size() > 0) last4 = q4.pop_front();
        end
        @(negedge clk);
        check("out_valid_pulse", {30'b0, ov0, ov4}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd_reg(4'(i));
            check($sformatf("filt_pt[%0d]", i), rd0, sx(last0[i]));
            check($sformatf("filt_avg[%0d]", i), rd4, sx(last4[i]));
        end
    endtask

    initial begin
        logic closes;
        reset_n = 1'b0;
        sample_strobe = 1'b0;
        {raw_5, raw_4, raw_3, raw_2, raw_1, raw_0} = '0;
        address = '0;
        wr = 1'b0;
        wr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_rd_data", rd4, 32'd0);
        check("reset_outs", {30'b0, ov4, busy4}, 32'd0);
        reset_n = 1'b1;
        rd_reg(4'd6);
        check("reset_status", rd4, 32'd0);

        // 4-sample block on channel 1 with offset 100: (100+200+300+400)/4 = 250
        wr_reg(4'd9, 16'd100);
        rd_reg(4'd9);
        check("offset1_readback", rd4, 32'd100);
        run_sample(mk(16'd5, 16'd200, 16'd0, 16'hFFF9, 16'd1000, 16'h8001), -1, 1'b0, 4'd0, 16'd0);
        run_sample(mk(16'd6, 16'd300, 16'd0, 16'hFFF0, 16'd1001, 16'h8002), -1, 1'b0, 4'd0, 16'd0);
        run_sample(mk(16'd7, 16'd400, 16'd0, 16'hFF00, 16'd1002, 16'h8003), -1, 1'b0, 4'd0, 16'd0);
        run_sample(mk(16'd8, 16'd500, 16'd0, 16'h0003, 16'd1003, 16'h8004), -1, 1'b0, 4'd0, 16'd0);
        rd_reg(4'd1);
        check("avg_ch1_250", rd4, 32'd250);
        rd_reg(4'd6);
        check("status_count4", rd4, 32'h0004_0000);

        // pass-through of 0x1234
        run_sample(mk(16'h1234, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0), -1, 1'b0, 4'd0, 16'd0);
        rd_reg(4'd0);
        check("passthru_1234", rd0, 32'h0000_1234);

        // 0x8000 - 1: saturates or wraps
        wr_reg(4'd10, 16'd1);
        run_sample(mk(16'd0, 16'd0, 16'h8000, 16'd0, 16'd0, 16'd0), -1, 1'b0, 4'd0, 16'd0);
        rd_reg(4'd2);
`ifdef IMU_FILTER_SAT_EN
        check("sub_edge", rd0, 32'hFFFF_8000);
`else
        check("sub_edge", rd0, 32'h0000_7FFF);
`endif

        // overrun: strobe dropped at cycle 3, sticky, cleared by host
        run_sample(mk(16'd11, 16'd22, 16'd33, 16'd44, 16'd55, 16'd66), 3, 1'b0, 4'd0, 16'd0);
        rd_reg(4'd6);
        check("status_overrun", rd4, {16'(cnt_m), 14'b0, ovr_m, 1'b0});
        check("overrun_set", {31'b0, rd4[1]}, 32'd1);
        wr_reg(4'd6, 16'h0002);
        rd_reg(4'd6);
        check("overrun_clear", rd4, {16'(cnt_m), 14'b0, ovr_m, 1'b0});

        // offset write coinciding with the latching strobe is not used by it
        run_sample(mk(16'd500, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0), -1, 1'b1, 4'd8, 16'd16);
        run_sample(mk(16'd500, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0), -1, 1'b0, 4'd0, 16'd0);
        rd_reg(4'd0);
        check("offset_new_used", rd0, 32'd484);

        // reset in the middle of CAL
        {raw_5, raw_4, raw_3, raw_2, raw_1, raw_0} = mk(16'd999, 16'd999, 16'd999, 16'd999, 16'd999, 16'd999);
        address = 4'd0;
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_rd", rd4, 32'd0);
        check("midreset_outs", {28'b0, ov0, busy0, ov4, busy4}, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        rd_reg(4'd8);
        check("midreset_offset", rd4, 32'd0);
        run_sample(mk(16'd10, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0), -1, 1'b0, 4'd0, 16'd0);
        run_sample(mk(16'd20, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0), -1, 1'b0, 4'd0, 16'd0);
        run_sample(mk(16'd30, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0), -1, 1'b0, 4'd0, 16'd0);
        run_sample(mk(16'd41, 16'hFFFE, 16'd0, 16'd0, 16'd0, 16'd0), -1, 1'b0, 4'd0, 16'd0);
        rd_reg(4'd0);
        check("post_reset_avg0", rd4, 32'd25);
        rd_reg(4'd1);
        check("post_reset_avg1_neg", rd4, 32'hFFFF_FFFE);
        rd_reg(4'd6);
        check("post_reset_status", rd4, 32'h0004_0000);
        closes = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
